// File: rtl/issue_stage.sv
// Scoreboarded in-order issue stage with a single registered output slot.
// Define ISSUE_BYPASS_EN to forward same-cycle writeback data into the operands.
module issue_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_payload,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_use1,
  input  logic            in_use2,
  input  logic            in_rd_we,
  output logic [4:0]      reg1_addr,
  output logic [4:0]      reg2_addr,
  input  logic [XLEN-1:0] reg1_value,
  input  logic [XLEN-1:0] reg2_value,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            sb_clr_valid,
  input  logic [4:0]      sb_clr_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_payload,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [31:0]     busy_mask
);

  typedef logic [XLEN-1:0] word_t;

  logic [31:0] pending_q, pending_d;
  logic        out_valid_q, out_valid_d;
  word_t       out_pc_q, out_pc_d;
  logic [31:0] out_payload_q, out_payload_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_rd_we_q, out_rd_we_d;
  word_t       out_op1_q, out_op1_d;
  word_t       out_op2_q, out_op2_d;

  logic byp1, byp2, raw1, raw2, waw, hazard, accept;

  assign reg1_addr = in_rs1;
  assign reg2_addr = in_rs2;

`ifdef ISSUE_BYPASS_EN
  assign byp1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
  assign byp2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign raw1     = in_use1 && (in_rs1 != 5'd0) && pending_q[in_rs1] && !byp1;
  assign raw2     = in_use2 && (in_rs2 != 5'd0) && pending_q[in_rs2] && !byp2;
  assign waw      = in_rd_we && (in_rd != 5'd0) && pending_q[in_rd];
  assign hazard   = raw1 || raw2 || waw;
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Clears are applied first so a same-cycle set of the same bit wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid)     pending_d[wb_rd]     = 1'b0;
    if (sb_clr_valid) pending_d[sb_clr_rd] = 1'b0;
    if (flush && out_valid_q && out_rd_we_q) pending_d[out_rd_q] = 1'b0;
    if (accept && in_rd_we) pending_d[in_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_payload_d = out_payload_q;
    out_rd_d      = out_rd_q;
    out_rd_we_d   = out_rd_we_q;
    out_op1_d     = out_op1_q;
    out_op2_d     = out_op2_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_pc_d      = in_pc;
      out_payload_d = in_payload;
      out_rd_d      = in_rd;
      out_rd_we_d   = in_rd_we;
      out_op1_d     = !in_use1 ? '0 : (byp1 ? wb_data : reg1_value);
      out_op2_d     = !in_use2 ? '0 : (byp2 ? wb_data : reg2_value);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q     <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_payload_q <= '0;
      out_rd_q      <= '0;
      out_rd_we_q   <= 1'b0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
    end else begin
      pending_q     <= pending_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_payload_q <= out_payload_d;
      out_rd_q      <= out_rd_d;
      out_rd_we_q   <= out_rd_we_d;
      out_op1_q     <= out_op1_d;
      out_op2_q     <= out_op2_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_payload = out_payload_q;
  assign out_rd      = out_rd_q;
  assign out_rd_we   = out_rd_we_q;
  assign out_op1     = out_op1_q;
  assign out_op2     = out_op2_q;
  assign busy_mask   = pending_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: queue-based scoreboard model checked every cycle, plus directed scenarios.
module tb_issue_stage;
  localparam int unsigned XLEN = 64;
`ifdef ISSUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid, in_ready, in_use1, in_use2, in_rd_we;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_payload;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic [4:0]      reg1_addr, reg2_addr;
  logic [XLEN-1:0] reg1_value, reg2_value;
  logic            wb_valid, sb_clr_valid, flush;
  logic [4:0]      wb_rd, sb_clr_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, out_ready, out_rd_we;
  logic [XLEN-1:0] out_pc, out_op1, out_op2;
  logic [31:0]     out_payload, busy_mask;
  logic [4:0]      out_rd;

  logic [XLEN-1:0] rf [32];
  assign reg1_value = rf[reg1_addr];
  assign reg2_value = rf[reg2_addr];

  always #5 clk = ~clk;

  issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_payload(in_payload),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use1(in_use1), .in_use2(in_use2), .in_rd_we(in_rd_we),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
    .reg1_value(reg1_value), .reg2_value(reg2_value),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .sb_clr_valid(sb_clr_valid), .sb_clr_rd(sb_clr_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_payload(out_payload), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_op1(out_op1), .out_op2(out_op2), .busy_mask(busy_mask)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: outstanding destinations as a list; issued instruction as plain fields.
  int              pend_q[$];
  bit              m_valid;
  logic [XLEN-1:0] m_pc, m_op1, m_op2;
  logic [31:0]     m_payload;
  logic [4:0]      m_rd;
  bit              m_rd_we;

  function automatic bit is_pend(input int r);
    foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void unpend(input int r);
    for (int i = pend_q.size() - 1; i >= 0; i--) if (pend_q[i] == r) pend_q.delete(i);
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (pend_q[i]) m[pend_q[i]] = 1'b1;
    return m;
  endfunction

  function automatic bit fwd(input logic [4:0] r);
    return Byp && wb_valid && (wb_rd == r) && (r != 5'd0);
  endfunction

  function automatic bit exp_ready();
    bit stall;
    stall = (in_use1 && in_rs1 != 0 && is_pend(int'(in_rs1)) && !fwd(in_rs1)) ||
            (in_use2 && in_rs2 != 0 && is_pend(int'(in_rs2)) && !fwd(in_rs2)) ||
            (in_rd_we && in_rd != 0 && is_pend(int'(in_rd)));
    return (!m_valid || out_ready) && !stall && !flush;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    chk("in_ready", in_ready, exp_ready());
    chk("reg1_addr", reg1_addr, in_rs1);
    chk("reg2_addr", reg2_addr, in_rs2);
    chk("busy_mask", busy_mask, model_mask());
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_payload", out_payload, m_payload);
      chk("out_rd", out_rd, m_rd);
      chk("out_rd_we", out_rd_we, m_rd_we);
      chk("out_op1", out_op1, m_op1);
      chk("out_op2", out_op2, m_op2);
    end
  endtask

  task automatic advance();
    bit acc;
    logic [XLEN-1:0] o1, o2;
    acc = in_valid && exp_ready();
    o1 = !in_use1 ? '0 : (fwd(in_rs1) ? wb_data : rf[in_rs1]);
    o2 = !in_use2 ? '0 : (fwd(in_rs2) ? wb_data : rf[in_rs2]);
    @(posedge clk);
    #1;
    if (wb_valid) unpend(int'(wb_rd));
    if (sb_clr_valid) unpend(int'(sb_clr_rd));
    if (flush && m_valid && m_rd_we) unpend(int'(m_rd));
    if (acc && in_rd_we && in_rd != 0) pend_q.push_back(int'(in_rd));
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_pc = in_pc; m_payload = in_payload;
      m_rd = in_rd; m_rd_we = in_rd_we; m_op1 = o1; m_op2 = o2;
    end else if (out_ready) m_valid = 1'b0;
    if (wb_valid && wb_rd != 0) rf[wb_rd] = wb_data;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle();
    in_valid = 0; in_use1 = 0; in_use2 = 0; in_rd_we = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_pc = '0; in_payload = '0;
    wb_valid = 0; wb_rd = 0; wb_data = '0; sb_clr_valid = 0; sb_clr_rd = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic hard_reset();
    rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_op1", out_op1, 0);
    chk("rst_out_rd_we", out_rd_we, 0);
    pend_q.delete();
    m_valid = 0;
    #1 rst = 1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : {$urandom, $urandom};
    idle();
    @(posedge clk);
    #1;
    hard_reset();

    // RAW on rd=5 resolved by writeback of 0xAB
    in_valid = 1; in_rd = 5; in_rd_we = 1; in_pc = 64'h1000;
    step();
    in_rd_we = 0; in_rd = 0; in_rs1 = 5; in_use1 = 1; in_pc = 64'h1004;
    settle(); chk("raw_stall", in_ready, 0); chk("raw_busy5", busy_mask[5], 1); advance();
    wb_valid = 1; wb_rd = 5; wb_data = 64'hAB;
    settle(); chk("wb_cycle_ready", in_ready, Byp); advance();
    wb_valid = 0;
    settle(); chk("bypass_timing", out_valid, Byp); chk("post_wb_ready", in_ready, 1); advance();
    in_valid = 0;
    settle(); chk("raw_op1", out_op1, 64'hAB); chk("raw_pc", out_pc, 64'h1004); advance();

    // rd=0 never becomes pending
    idle(); in_valid = 1; in_rd = 0; in_rd_we = 1;
    step();
    in_rd_we = 0; in_rs1 = 0; in_use1 = 1;
    settle(); chk("x0_busy", busy_mask, 0); chk("x0_ready", in_ready, 1); advance();

    // Backpressure for 3 cycles
    idle(); step();
    in_valid = 1; in_pc = 64'h100; out_ready = 0;
    step();
    in_pc = 64'h200;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("bp_ready", in_ready, 0); chk("bp_hold_pc", out_pc, 64'h100); advance();
    end
    out_ready = 1;
    settle(); chk("bp_release", in_ready, 1); advance();
    in_valid = 0;
    settle(); chk("bp_next_pc", out_pc, 64'h200); chk("bp_next_valid", out_valid, 1); advance();

    // Flush of a held rd=7 writer
    idle(); step();
    in_valid = 1; in_rd = 7; in_rd_we = 1; out_ready = 0;
    step();
    in_valid = 0; in_rd_we = 0; in_rd = 0; flush = 1;
    settle(); chk("flush_busy_before", busy_mask[7], 1); advance();
    flush = 0; in_valid = 1; in_rs1 = 7; in_use1 = 1;
    settle(); chk("flush_valid", out_valid, 0); chk("flush_busy_after", busy_mask[7], 0);
    chk("flush_no_stall", in_ready, 1); advance();

    // Set wins over same-cycle writeback clear
    idle(); step();
    in_valid = 1; in_rd = 3; in_rd_we = 1; wb_valid = 1; wb_rd = 3; wb_data = 64'h33;
    step();
    idle();
    settle(); chk("set_wins", busy_mask[3], 1); advance();
    wb_valid = 1; wb_rd = 3; wb_data = 64'h34;
    step();

    // Asynchronous reset mid-stall, then accept on first edge
    idle(); step();
    in_valid = 1; in_rd = 9; in_rd_we = 1; out_ready = 0;
    step();
    in_rd = 0; in_rd_we = 0; in_rs1 = 9; in_use1 = 1; out_ready = 1;
    settle(); chk("pre_rst_stall", in_ready, 0); advance();
    hard_reset();
    settle(); chk("post_rst_ready", in_ready, 1); advance();
    in_valid = 0;
    settle(); chk("post_rst_accept", out_valid, 1); advance();

    // Randomized traffic
    idle();
    for (int c = 0; c < 4000; c++) begin
      in_valid   = ($urandom_range(0, 9) < 6);
      in_rs1     = 5'($urandom_range(0, 7));
      in_rs2     = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 7));
      in_use1    = 1'($urandom_range(0, 1));
      in_use2    = 1'($urandom_range(0, 1));
      in_rd_we   = 1'($urandom_range(0, 1));
      in_pc      = {$urandom, $urandom};
      in_payload = $urandom;
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 99) < 3);
      wb_valid   = ($urandom_range(0, 9) < 3);
      wb_data    = {$urandom, $urandom};
      if (pend_q.size() > 0 && $urandom_range(0, 4) != 0)
        wb_rd = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
      else
        wb_rd = 5'($urandom_range(0, 7));
      sb_clr_valid = ($urandom_range(0, 99) < 5);
      if (pend_q.size() > 0)
        sb_clr_rd = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
      else
        sb_clr_rd = 5'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/issue_stage.md
ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 Parameter: XLEN, 64, operand/PC width (word_t).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 in_valid/in_ready  in/out  1/1  decoded-instruction handshake.
REQ-006 in_pc  in  XLEN  PC. in_payload  in  32  opaque control bits.
REQ-007 in_rs1, in_rs2, in_rd  in  5 each  register indices. in_use1, in_use2, in_rd_we  in  1 each  source-use and write flags.
REQ-008 reg1_addr, reg2_addr  out  5 each  register-file read addresses. reg1_value, reg2_value  in  XLEN each  read data.
REQ-009 wb_valid, wb_rd, wb_data  in  1/5/XLEN  writeback, same values as the register-file write port.
REQ-010 sb_clr_valid, sb_clr_rd  in  1/5  clears a pending bit without a write (squashed downstream instruction).
REQ-011 flush  in  1  discards the held instruction.
REQ-012 out_valid/out_ready  out/in  1/1  execute-side handshake.
REQ-013 out_pc, out_payload, out_rd, out_rd_we, out_op1, out_op2  out  XLEN/32/5/1/XLEN/XLEN  issued instruction and operands.
REQ-014 busy_mask  out  32  scoreboard pending bits.

Function
REQ-015 reg1_addr=in_rs1 and reg2_addr=in_rs2, combinationally.
REQ-016 Scoreboard: pending[31:0]; bit 0 is never set.
REQ-017 RAW hazard on a source: in_useN, rsN!=0, pending[rsN]=1, and no bypass hit (REQ-028).
REQ-018 WAW hazard: in_rd_we, in_rd!=0, pending[in_rd]=1; the bypass never cancels it.
REQ-019 in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-020 Accept (in_valid & in_ready): all out_* load at the next edge; out_valid=1; latency 1 cycle.
REQ-021 On accept with in_rd_we & in_rd!=0: pending[in_rd] sets at the same edge; out_rd_we and out_rd are passed through unchanged.
REQ-022 out_opN = reg value, or the bypass value (REQ-028); 0 when in_useN=0.
REQ-023 out_valid & !out_ready: all out_* hold stable; operands are not re-read.
REQ-024 out_valid & out_ready with no accept: out_valid clears at the next edge.
REQ-025 wb_valid clears pending[wb_rd]; sb_clr_valid clears pending[sb_clr_rd]; both act in the same cycle; an index of 0 is ignored.
REQ-026 Set and clear of the same bit in one cycle: the set wins.
REQ-027 flush: out_valid clears at the next edge; pending[out_rd] clears if out_valid & out_rd_we; no accept occurs in that cycle.

Configuration
REQ-028 ISSUE_BYPASS_EN defined: a source with wb_valid & wb_rd==rsN & rsN!=0 takes wb_data and has no RAW hazard.
REQ-029 ISSUE_BYPASS_EN undefined: no forwarding; the stall lasts until the cycle after wb_valid, when the register-file read returns the new value.

Reset
REQ-030 rst low (asynchronous): out_valid=0, pending=0, out_pc/out_payload/out_op1/out_op2/out_rd/out_rd_we=0.
REQ-031 Reset mid-operation drops the held instruction; the first accept is possible at the first edge after rst rises.

Verification
REQ-032 Issue rd=5 with out_ready=1, then next cycle rs1=5 -> in_ready=0, busy_mask[5]=1; wb_valid rd=5 data=0xAB -> bypass: accept that cycle with out_op1=0xAB; no bypass: accept one cycle later with out_op1=0xAB.
REQ-033 rd=0 with rd_we=1 -> busy_mask stays 0; a following rs1=0 never stalls.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; out_* stable; release -> next instruction issues one cycle later.
REQ-035 Issue rd=7, flush while held -> out_valid=0 and busy_mask[7]=0 next cycle; a subsequent rs1=7 issues without stall.
REQ-036 Accept rd=3 while wb_valid rd=3 in the same cycle (rd=3 not previously pending) -> busy_mask[3]=1 afterwards.
REQ-037 rst low mid-stall -> out_valid=0 and busy_mask=0 immediately, without a clock edge.
